// File: rtl/chip8_pkg.sv
// ----------------------------------------------------------------------------
// chip8_pkg
// Shared types and constants for the CHIP-8 memory subsystem.
//   ADDR_W / DATA_W : geometry of the single-port 4 KiB RAM.
//   req_idx_e       : requester slot numbers on the arbiter (loader, CPU, draw).
//   lock_state_e    : bus-lock state of the arbiter.
//   mem_req_t       : one RAM port command (write enable, address, write data).
// ----------------------------------------------------------------------------
package chip8_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        REQ_LOADER = 2'd0,
        REQ_CPU    = 2'd1,
        REQ_DRAW   = 2'd2
    } req_idx_e;

    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/chip8_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// chip8_mem_arbiter_if
// Bundle of the requester handshake signals and the RAM port of the arbiter.
//   req_valid/req_we/req_lock : per-requester request, direction, lock hint
//   req_addr/req_wdata        : packed per-requester fields (slot k at slice k)
//   req_ready                 : one-hot grant
//   rsp_valid/rsp_data        : one-hot read strobe and shared read data
//   mem_addr/mem_we/mem_wdata : registered RAM command
//   mem_rdata                 : RAM read data (one cycle after address sample)
// Modports: slave = arbiter side, master = requesters plus RAM side.
// ----------------------------------------------------------------------------
interface chip8_mem_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = chip8_pkg::ADDR_W,
    parameter int DATA_W  = chip8_pkg::DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_data, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/chip8_rr_picker.sv
// ----------------------------------------------------------------------------
// chip8_rr_picker
// Combinational rotating-base priority encoder. Searches req starting at
// index base, wrapping modulo NUM_REQ; the first set bit wins.
//   req   : request vector
//   base  : index with highest priority this cycle (tie to 0 for fixed order)
//   grant : one-hot winner, zero when req is zero
// ----------------------------------------------------------------------------
module chip8_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic [NUM_REQ-1:0] grant
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(base) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// ----------------------------------------------------------------------------
// chip8_mem_arbiter
// Shares the single-port CHIP-8 RAM between the loader (0), CPU (1) and draw
// engine (2). One transfer per cycle; the RAM command is registered; read data
// returns to the issuing requester two edges after the transfer edge.
// A requester may lock the bus for its next access (opcode byte pair, sprite
// row pair); the lock is dropped after LOCK_MAX idle locked cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : chip8_mem_arbiter_if.slave (handshakes + RAM port)
// Build option:
//   CHIP8_ARB_RR_EN defined   -> round-robin arbitration
//   CHIP8_ARB_RR_EN undefined -> fixed priority, lowest index wins
// ----------------------------------------------------------------------------
module chip8_mem_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = chip8_pkg::ADDR_W,
    parameter int DATA_W   = chip8_pkg::DATA_W,
    parameter int LOCK_MAX = 4
) (
    input logic                clk,
    input logic                rst_n,
    chip8_mem_arbiter_if.slave bus
);
    import chip8_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    mem_req_t           mem_q, mem_d;
    lock_state_e        lock_q, lock_d;
    logic [NUM_REQ-1:0] owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] rd_pend_q, rd_pend_d;     // read issued, RAM samples next edge
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [IDX_W-1:0]   base;
    logic [NUM_REQ-1:0] pick_grant;
    logic [NUM_REQ-1:0] ready;
    logic               any_xfer;
    logic [IDX_W-1:0]   win_idx;

`ifdef CHIP8_ARB_RR_EN
    logic [IDX_W-1:0]   rr_q, rr_d;
    assign base = rr_q;
`else
    assign base = '0;
`endif

    chip8_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (bus.req_valid),
        .base  (base),
        .grant (pick_grant)
    );

    // Grant: the lock owner alone while locked; nothing while in reset.
    always_comb begin
        ready = '0;
        if (rst_n) begin
            if (lock_q == LOCK_HELD) ready = bus.req_valid & owner_q;
            else                     ready = pick_grant;
        end
        any_xfer = |ready;
        win_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready[i]) win_idx = IDX_W'(i);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        mem_d       = mem_q;
        mem_d.we    = 1'b0;
        rd_pend_d   = '0;
        rsp_valid_d = rd_pend_q;
        lock_d      = lock_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;

        if (any_xfer) begin
            mem_d.we    = bus.req_we[win_idx];
            mem_d.addr  = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_d.wdata = bus.req_wdata[win_idx*DATA_W +: DATA_W];
            if (!bus.req_we[win_idx]) rd_pend_d = ready;
        end

        if (any_xfer && bus.req_lock[win_idx]) begin
            // Arms a new lock or re-arms the current one.
            lock_d  = LOCK_HELD;
            owner_d = ready;
            cnt_d   = '0;
        end else if (lock_q == LOCK_HELD) begin
            if (any_xfer || cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                // Owner finished its pair, or the counter is about to reach
                // LOCK_MAX: free the bus from the next cycle on.
                lock_d = LOCK_FREE;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

`ifdef CHIP8_ARB_RR_EN
    // Only transfers made while unlocked advance the pointer.
    always_comb begin
        rr_d = rr_q;
        if (any_xfer && lock_q == LOCK_FREE) begin
            rr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '0;
            lock_q      <= LOCK_FREE;
            owner_q     <= '0;
            cnt_q       <= '0;
            rd_pend_q   <= '0;
            rsp_valid_q <= '0;
`ifdef CHIP8_ARB_RR_EN
            rr_q        <= '0;
`endif
        end else begin
            mem_q       <= mem_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= rd_pend_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef CHIP8_ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = bus.mem_rdata;
    assign bus.mem_addr  = mem_q.addr;
    assign bus.mem_we    = mem_q.we;
    assign bus.mem_wdata = mem_q.wdata;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_chip8_mem_arbiter
// Self-checking bench for chip8_mem_arbiter with a behavioural 4 KiB RAM.
// Expected grants come from a vector table (separate columns for fixed and
// round-robin builds, selected by CHIP8_ARB_RR_EN); expected read responses
// are queued from a shadow copy of RAM when a read is predicted to transfer.
// ----------------------------------------------------------------------------
module tb_chip8_mem_arbiter;
    import chip8_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 12;
    localparam int DW   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chip8_mem_arbiter_if #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

    chip8_mem_arbiter #(
        .NUM_REQ  (NREQ),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .LOCK_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM: synchronous write, one-cycle synchronous read.
    logic [7:0] ram    [4096];
    logic [7:0] shadow [4096];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  we;
        logic [2:0]  lock;
        logic [35:0] addr;
        logic [23:0] wdata;
        logic [2:0]  exp_ready;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         due;
    } rsp_t;

    rsp_t       sb[$];
    rsp_t       mon_e;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [11:0] exp_addr = '0;
    logic [7:0]  exp_wdata = '0;
    logic        exp_we;
    vec_t        vecs[20];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic [2:0] valid, input logic [2:0] we,
                                input logic [2:0] lock, input logic [11:0] a0,
                                input logic [11:0] a1, input logic [11:0] a2,
                                input logic [7:0] wd, input logic [2:0] exp_fixed,
                                input logic [2:0] exp_rr);
        vec_t v;
        v.valid = valid;
        v.we    = we;
        v.lock  = lock;
        v.addr  = {a2, a1, a0};
        v.wdata = {3{wd}};
`ifdef CHIP8_ARB_RR_EN
        v.exp_ready = exp_rr;
`else
        v.exp_ready = exp_fixed;
`endif
        return v;
    endfunction

    // One cycle: drive at a falling edge, check the grant, predict the
    // transfer, then check the registered RAM command at the next falling edge.
    task automatic step(input string tag, input vec_t v);
        bus.req_valid = v.valid;
        bus.req_we    = v.we;
        bus.req_lock  = v.lock;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        #1;
        check({tag, "_ready"}, 32'(bus.req_ready), 32'(v.exp_ready));
        exp_we = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (v.exp_ready[k]) begin
                exp_addr  = v.addr[k*12 +: 12];
                exp_wdata = v.wdata[k*8 +: 8];
                if (v.we[k]) begin
                    exp_we = 1'b1;
                    shadow[exp_addr] = exp_wdata;
                end else begin
                    sb.push_back('{k, shadow[exp_addr], cyc + 2});
                end
            end
        end
        @(negedge clk);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'(exp_we));
        check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'(exp_addr));
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(exp_wdata));
    endtask

    // Response monitor: every strobe must match the oldest queued read.
    always @(negedge clk) begin
        if (bus.rsp_valid !== 3'b000) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_strobe", 32'(bus.rsp_valid), 32'(1) << mon_e.idx);
                check("rsp_data",   32'(bus.rsp_data),  32'(mon_e.data));
                check("rsp_cycle",  32'(cyc),           32'(mon_e.due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        ram[12'h200]    = 8'hA2;
        shadow[12'h200] = 8'hA2;

        //              valid   we      lock    a0      a1      a2      wd     fixed   rr
        vecs[0]  = mk(3'b000, 3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 3'b000, 3'b000);
        vecs[1]  = mk(3'b010, 3'b000, 3'b000, 12'h000, 12'h200, 12'h000, 8'h00, 3'b010, 3'b010);
        vecs[2]  = mk(3'b001, 3'b001, 3'b000, 12'h050, 12'h000, 12'h000, 8'h55, 3'b001, 3'b001);
        vecs[3]  = mk(3'b010, 3'b000, 3'b000, 12'h000, 12'h050, 12'h000, 8'h00, 3'b010, 3'b010);
        vecs[4]  = mk(3'b111, 3'b000, 3'b000, 12'h010, 12'h020, 12'h030, 8'h00, 3'b001, 3'b100);
        vecs[5]  = mk(3'b111, 3'b000, 3'b000, 12'h010, 12'h020, 12'h030, 8'h00, 3'b001, 3'b001);
        vecs[6]  = mk(3'b111, 3'b000, 3'b000, 12'h010, 12'h020, 12'h030, 8'h00, 3'b001, 3'b010);
        vecs[7]  = mk(3'b111, 3'b000, 3'b000, 12'h010, 12'h020, 12'h030, 8'h00, 3'b001, 3'b100);
        vecs[8]  = mk(3'b000, 3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 3'b000, 3'b000);
        vecs[9]  = mk(3'b110, 3'b000, 3'b010, 12'h000, 12'h200, 12'h300, 8'h00, 3'b010, 3'b010);
        vecs[10] = mk(3'b110, 3'b000, 3'b000, 12'h000, 12'h201, 12'h300, 8'h00, 3'b010, 3'b010);
        vecs[11] = mk(3'b100, 3'b000, 3'b000, 12'h000, 12'h000, 12'h300, 8'h00, 3'b100, 3'b100);
        vecs[12] = mk(3'b011, 3'b000, 3'b001, 12'h061, 12'h202, 12'h000, 8'h00, 3'b001, 3'b001);
        vecs[13] = mk(3'b010, 3'b000, 3'b000, 12'h000, 12'h202, 12'h000, 8'h00, 3'b000, 3'b000);
        vecs[14] = mk(3'b011, 3'b000, 3'b000, 12'h062, 12'h202, 12'h000, 8'h00, 3'b001, 3'b001);
        vecs[15] = mk(3'b010, 3'b000, 3'b000, 12'h000, 12'h202, 12'h000, 8'h00, 3'b010, 3'b010);
        vecs[16] = mk(3'b110, 3'b000, 3'b000, 12'h000, 12'h203, 12'h304, 8'h00, 3'b010, 3'b100);
        vecs[17] = mk(3'b011, 3'b001, 3'b000, 12'h0A0, 12'h0A0, 12'h000, 8'h3C, 3'b001, 3'b001);
        vecs[18] = mk(3'b010, 3'b000, 3'b000, 12'h000, 12'h0A0, 12'h000, 8'h00, 3'b010, 3'b010);
        vecs[19] = mk(3'b000, 3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 3'b000, 3'b000);

        // Reset state with all requesters asking: nothing may be granted.
        bus.req_valid = 3'b111;
        bus.req_we    = 3'b000;
        bus.req_lock  = 3'b000;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready",     32'(bus.req_ready), 32'h0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
        check("rst_mem_we",    32'(bus.mem_we),    32'h0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        bus.req_valid = 3'b000;
        rst_n = 1'b1;
        @(negedge clk);

        // Reset pulsed between the transfer edge and the RAM sample edge.
        bus.req_valid = 3'b010;
        bus.req_addr  = {12'h000, 12'h200, 12'h000};
        #1;
        check("mr_ready", 32'(bus.req_ready), 32'b010);
        @(posedge clk);
        #1;
        check("mr_mem_addr", 32'(bus.mem_addr), 32'h200);
        rst_n = 1'b0;
        #1;
        check("mr_rst_ready",     32'(bus.req_ready), 32'h0);
        check("mr_rst_mem_addr",  32'(bus.mem_addr),  32'h0);
        check("mr_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        @(negedge clk);
        bus.req_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr  = '0;
        exp_wdata = '0;

        for (int i = 0; i < 20; i++) step($sformatf("v%0d", i), vecs[i]);

        // Lock timeout: CPU locks then goes quiet; draw waits LOCK_MAX cycles.
        step("to_lock", mk(3'b010, 3'b000, 3'b010, 12'h000, 12'h203, 12'h000, 8'h00, 3'b010, 3'b010));
        for (int i = 0; i < 4; i++)
            step($sformatf("to_hold%0d", i),
                 mk(3'b100, 3'b000, 3'b000, 12'h000, 12'h000, 12'h301, 8'h00, 3'b000, 3'b000));
        step("to_free", mk(3'b100, 3'b000, 3'b000, 12'h000, 12'h000, 12'h301, 8'h00, 3'b100, 3'b100));

        // Re-arm: a second locked transfer restarts the timeout count.
        step("ra_lock", mk(3'b010, 3'b000, 3'b010, 12'h000, 12'h204, 12'h000, 8'h00, 3'b010, 3'b010));
        for (int i = 0; i < 2; i++)
            step($sformatf("ra_wait%0d", i),
                 mk(3'b100, 3'b000, 3'b000, 12'h000, 12'h000, 12'h302, 8'h00, 3'b000, 3'b000));
        step("ra_rearm", mk(3'b110, 3'b000, 3'b010, 12'h000, 12'h205, 12'h302, 8'h00, 3'b010, 3'b010));
        for (int i = 0; i < 4; i++)
            step($sformatf("ra_hold%0d", i),
                 mk(3'b100, 3'b000, 3'b000, 12'h000, 12'h000, 12'h302, 8'h00, 3'b000, 3'b000));
        step("ra_free", mk(3'b100, 3'b000, 3'b000, 12'h000, 12'h000, 12'h302, 8'h00, 3'b100, 3'b100));

        for (int i = 0; i < 3; i++)
            step($sformatf("flush%0d", i),
                 mk(3'b000, 3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 8'h00, 3'b000, 3'b000));
        check("rsp_outstanding", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chip8_mem_arbiter.md
Name: chip8_mem_arbiter

Overview:
- Shares the single-port 4 KiB CHIP-8 RAM (sync write, 1-cycle sync read) between three requesters: ROM/font loader, CPU fetch/execute, and the sprite/display engine.
- Arbitrates per access with valid/ready handshakes, drives the RAM port from registers, and routes read data back to the issuing requester.
- Supports a short bus lock so the CPU can fetch both opcode bytes, or a DXYN sprite row pair, without interleaving.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 is the loader, 1 the CPU, 2 the draw engine.
- ADDR_W, 12, RAM address width.
- DATA_W, 8, RAM data width.
- LOCK_MAX, 4, maximum consecutive cycles a lock may hold off other requesters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  reserve the next grant for this requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester k at slice k.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid & ready at a rising edge.
- rsp_valid  out  NUM_REQ  one-hot read-data strobe.
- rsp_data  out  DATA_W  read data, meaningful only while any rsp_valid is high.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after RAM samples the address.

Behaviour:
- Reset (async, rst_n=0): mem_addr=0, mem_we=0, mem_wdata=0, rsp_valid=0, lock free, lock counter 0, RR pointer 0. req_ready=0 while in reset. Any in-flight read is dropped and produces no rsp_valid.
- req_ready is combinational from req_valid, lock state and priority state. It is always one-hot or zero, and is zero when no req_valid is high.
- Throughput: one transfer per cycle, with back-to-back transfers from different requesters allowed.
- On the transfer edge T:
  - mem_addr, mem_we and mem_wdata load the winner's fields.
  - mem_we is 0 for reads and returns to 0 the next cycle unless another write transfers.
- Read latency: RAM samples at edge T+1. rsp_valid[k]=1 for exactly one cycle, between T+1 and T+2. rsp_data = mem_rdata passthrough.
- Writes produce no rsp_valid.
- Requester rules: fields must hold stable while valid is high and ready is low. Dropping valid before transfer is legal, with no side effect.
- Idle cycles (no transfer): mem_we=0; mem_addr and mem_wdata hold their last value.
- Lock:
  - A transfer with req_lock[k]=1 sets lock owner = k and clears the lock counter.
  - While locked, only k may receive req_ready. The counter increments on every locked cycle in which k does not transfer.
  - Lock releases when k transfers with req_lock=0, or when the counter reaches LOCK_MAX. The LOCK_MAX release is forced and takes effect on the next cycle.
  - A locked transfer with req_lock=1 re-arms the lock and clears the counter.
- Priority without lock:
  - Default (feature off): fixed priority, lowest index wins.
  - With the feature on: rotating priority, see Optional Feature.
- Simultaneous events:
  - Lock release and new requests in the same cycle: the release applies first, and the new grant follows normal priority in the next cycle.
  - Read response for A and a transfer from B in the same cycle are independent; both proceed.

Optional Feature:
- Macro: CHIP8_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at RR pointer p; after each non-locked transfer by k, p = (k+1) mod NUM_REQ. Locked transfers do not move p.
- Undefined: fixed priority (index 0 highest). The RR pointer register and its logic are absent.

Decomposition:
- Shared package chip8_pkg:
  - ADDR_W=12, DATA_W=8.
  - Requester index constants REQ_LOADER=0, REQ_CPU=1, REQ_DRAW=2.
  - mem_req_t struct (we, addr, wdata).
- One natural sub-module: chip8_rr_picker. It is a combinational rotating-base priority encoder taking the request vector and base index and returning the one-hot grant. Fixed mode ties the base to 0.

Test Plan:
- Reset mid-read: CPU reads 0x200 at edge T, rst_n pulsed low before T+1 -> no rsp_valid; all outputs 0 during reset.
- Single read: RAM[0x200]=0xA2; CPU req 0x200 -> req_ready[1] high same cycle; mem_addr=0x200 after T; rsp_valid=3'b010 with rsp_data=0xA2 between T+1 and T+2.
- Contention, fixed mode: all three valid, continuously re-requesting -> grants 0,0,0… (loader starves others while valid). With CHIP8_ARB_RR_EN -> grants 0,1,2,0,1,2.
- Lock pair: CPU reads 0x200 with lock=1, then 0x201 with lock=0 while draw engine is valid -> draw gets no ready between the two; draw granted the cycle after 0x201.
- Lock timeout: CPU locks then drops valid; draw valid -> draw ready stays 0 for LOCK_MAX=4 cycles, then the lock is released and draw is granted on the next cycle.
- Write then read: loader writes 0x55 to 0x050, CPU reads 0x050 the next cycle -> mem_we=1 for exactly one cycle; CPU rsp_data=0x55.
